// File: rtl/uart_tx_fifo_pkg.sv
// uart_pkg: shared UART types and constants.
//   parity_e    : PARITY_NONE / PARITY_EVEN / PARITY_ODD parity selection
//   tx_state_e  : transmitter FSM state encoding (plain 3-bit vector with
//                 named localparam constants, so legacy code can use them too)
//   parity_bit  : parity of a payload word (zero-extend narrower words to 9 bits)
package uart_pkg;

  typedef enum logic [1:0] {
    PARITY_NONE = 2'd0,
    PARITY_EVEN = 2'd1,
    PARITY_ODD  = 2'd2
  } parity_e;

  typedef logic [2:0] tx_state_e;
  localparam tx_state_e ST_IDLE   = 3'd0;
  localparam tx_state_e ST_START  = 3'd1;
  localparam tx_state_e ST_DATA   = 3'd2;
  localparam tx_state_e ST_PARITY = 3'd3;
  localparam tx_state_e ST_STOP   = 3'd4;

  // Even parity makes the total count of ones even (bit = ^d);
  // odd parity makes it odd (bit = ~^d).
  function automatic logic parity_bit(input logic [8:0] d, input parity_e p);
    return (p == PARITY_ODD) ? ~^d : ^d;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: write-side handshake of the buffered UART transmitter.
//   wr_data_in     : word to queue               (master -> slave)
//   wr_valid_in    : push request                (master -> slave)
//   wr_ready_out   : FIFO not full, registered   (slave  -> master)
//   fifo_level_out : occupied FIFO entries       (slave  -> master)
interface uart_tx_fifo_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
);
  logic [DATA_BITS-1:0]          wr_data_in;
  logic                          wr_valid_in;
  logic                          wr_ready_out;
  logic [$clog2(FIFO_DEPTH):0]   fifo_level_out;

  modport master (output wr_data_in, wr_valid_in, input wr_ready_out, fifo_level_out);
  modport slave  (input wr_data_in, wr_valid_in, output wr_ready_out, fifo_level_out);
endinterface

// File: rtl/uart_tx_fifo_sync_fifo.sv
// sync_fifo: single-clock FIFO, pointer based with one extra pointer MSB to
// tell full from empty. First-word fall-through: rdata shows the head entry
// whenever empty=0.
//   clk, rst_n : clock, synchronous active-low reset (flushes pointers)
//   push/wdata : write; ignored unless ready=1
//   pop/rdata  : read head; ignored while empty
//   ready      : registered !full
//   empty      : no entries
//   level      : occupied entries, 0..DEPTH
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     ready,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic             ready_q, ready_d;
  logic             push_ok, pop_ok;

  // A push in the same cycle as a pop while full is refused because ready
  // still reflects the full state; the pop alone goes through.
  assign push_ok = push & ready_q;
  assign pop_ok  = pop & ~empty;

  always_comb begin
    wptr_d  = wptr_q + {{AW{1'b0}}, push_ok};
    rptr_d  = rptr_q + {{AW{1'b0}}, pop_ok};
    ready_d = ~((wptr_d[AW] != rptr_d[AW]) && (wptr_d[AW-1:0] == rptr_d[AW-1:0]));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      ready_q <= ready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

  assign rdata = mem_q[rptr_q[AW-1:0]];
  assign ready = ready_q;
  assign empty = (wptr_q == rptr_q);
  assign level = wptr_q - rptr_q;
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter. Words pushed through wr_if are
// queued in a sync_fifo and serialised back-to-back:
//   start(0), DATA_BITS LSB first, optional parity, STOP_BITS stop(1).
// Every bit edge lands on a baudpulse_in tick; each bit lasts OVERSAMPLING ticks.
// Ports:
//   sysclk_in      : system clock, all logic on posedge
//   nrst_in        : synchronous active-low reset; aborts any frame in flight
//   baudpulse_in   : 1-cycle oversample tick from the baud generator
//   wr_if (slave)  : wr_data_in / wr_valid_in / wr_ready_out / fifo_level_out
//   tx_serial_out  : serial line, idle high, driven from a flop
//   tx_busy_out    : frame in progress (low for the one IDLE cycle between frames)
//   tx_done_out    : 1-cycle pulse on the final stop-bit tick
//   cts_n_in       : clear-to-send, active low; present only with UART_TX_CTS_EN
// Macro UART_TX_CTS_EN: gate frame starts on a synchronised cts_n_in.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int OVERSAMPLING = 8,
  parameter int FIFO_DEPTH   = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic          sysclk_in,
  input  logic          nrst_in,
  input  logic          baudpulse_in,
  uart_tx_fifo_if.slave wr_if,
  output logic          tx_serial_out,
  output logic          tx_busy_out,
  output logic          tx_done_out
`ifdef UART_TX_CTS_EN
  ,
  input  logic          cts_n_in
`endif
);
  localparam int      TW  = $clog2(OVERSAMPLING) + 1;
  localparam int      BW  = $clog2(DATA_BITS) + 1;
  localparam parity_e PAR = parity_e'(2'(PARITY));

  tx_state_e             state_q, state_d;
  logic [TW-1:0]         tick_q, tick_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic                  par_q, par_d;
  logic                  line_q, line_d;
  logic                  done_q, done_d;
  logic                  lead_q, lead_d;    // word loaded, waiting for the start-bit tick
  logic                  pop;
  logic                  fifo_empty;
  logic [DATA_BITS-1:0]  fifo_rdata;
  logic                  bit_end;
  logic                  cts_ok;

  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (sysclk_in),
    .rst_n (nrst_in),
    .push  (wr_if.wr_valid_in),
    .wdata (wr_if.wr_data_in),
    .pop   (pop),
    .rdata (fifo_rdata),
    .ready (wr_if.wr_ready_out),
    .empty (fifo_empty),
    .level (wr_if.fifo_level_out)
  );

`ifdef UART_TX_CTS_EN
  logic [1:0] cts_sync_q, cts_sync_d;
  assign cts_sync_d = {cts_sync_q[0], cts_n_in};
  always_ff @(posedge sysclk_in) begin
    if (!nrst_in) cts_sync_q <= 2'b11;
    else          cts_sync_q <= cts_sync_d;
  end
  // Only the IDLE pop looks at CTS, so a frame already started always completes.
  assign cts_ok = ~cts_sync_q[1];
`else
  assign cts_ok = 1'b1;
`endif

  // Tick that closes the current bit; the next bit's level goes out on it.
  assign bit_end = baudpulse_in && (tick_q == TW'(OVERSAMPLING - 1));

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    line_d  = line_q;
    lead_d  = lead_q;
    done_d  = 1'b0;
    pop     = 1'b0;

    if (baudpulse_in && (state_q != ST_IDLE) && !lead_q)
      tick_d = bit_end ? '0 : tick_q + TW'(1);

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && cts_ok) begin
          pop     = 1'b1;
          shift_d = fifo_rdata;
          par_d   = parity_bit(9'(fifo_rdata), PAR);
          lead_d  = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (lead_q) begin
          if (baudpulse_in) begin
            line_d = 1'b0;
            lead_d = 1'b0;
            tick_d = '0;
          end
        end else if (bit_end) begin
          line_d  = shift_q[0];
          shift_d = shift_q >> 1;
          bit_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_q == BW'(DATA_BITS - 1)) begin
            if (PAR != PARITY_NONE) begin
              line_d  = par_q;
              state_d = ST_PARITY;
            end else begin
              line_d  = 1'b1;
              bit_d   = '0;
              state_d = ST_STOP;
            end
          end else begin
            line_d  = shift_q[0];
            shift_d = shift_q >> 1;
            bit_d   = bit_q + BW'(1);
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          line_d  = 1'b1;
          bit_d   = '0;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        // Line stays high through IDLE; a queued word's start bit goes out on
        // the very next tick, so frames run back-to-back with no idle bit.
        if (bit_end) begin
          if (bit_q == BW'(STOP_BITS - 1)) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sysclk_in) begin
    if (!nrst_in) begin
      state_q <= ST_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      line_q  <= 1'b1;
      done_q  <= 1'b0;
      lead_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      line_q  <= line_d;
      done_q  <= done_d;
      lead_q  <= lead_d;
    end
  end

  assign tx_serial_out = line_q;
  assign tx_busy_out   = (state_q != ST_IDLE);
  assign tx_done_out   = done_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo. Three instances share clock, reset and a
// baud tick every 4 clocks (OVERSAMPLING=8 -> 32 clocks per bit):
//   dut   : 8N1, depth 16
//   dut_p : 8 data, even parity, 2 stop
//   dut_o : 8 data, odd parity, 1 stop
// With UART_TX_CTS_EN defined the CTS scenario also runs.
module tb_uart_tx_fifo;
  logic clk, rst_n, baud;
  logic tx0, busy0, done0, tx1, busy1, done1, tx2, busy2, done2;
  int   errors, checks, done_cnt0;
`ifdef UART_TX_CTS_EN
  logic cts_n;
`endif

  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) m_if ();
  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) p_if ();
  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) o_if ();

  uart_tx_fifo #(.DATA_BITS(8), .OVERSAMPLING(8), .FIFO_DEPTH(16), .PARITY(0), .STOP_BITS(1)) dut (
    .sysclk_in(clk), .nrst_in(rst_n), .baudpulse_in(baud), .wr_if(m_if),
    .tx_serial_out(tx0), .tx_busy_out(busy0), .tx_done_out(done0)
`ifdef UART_TX_CTS_EN
    , .cts_n_in(cts_n)
`endif
  );
  uart_tx_fifo #(.DATA_BITS(8), .OVERSAMPLING(8), .FIFO_DEPTH(16), .PARITY(1), .STOP_BITS(2)) dut_p (
    .sysclk_in(clk), .nrst_in(rst_n), .baudpulse_in(baud), .wr_if(p_if),
    .tx_serial_out(tx1), .tx_busy_out(busy1), .tx_done_out(done1)
`ifdef UART_TX_CTS_EN
    , .cts_n_in(1'b0)
`endif
  );
  uart_tx_fifo #(.DATA_BITS(8), .OVERSAMPLING(8), .FIFO_DEPTH(16), .PARITY(2), .STOP_BITS(1)) dut_o (
    .sysclk_in(clk), .nrst_in(rst_n), .baudpulse_in(baud), .wr_if(o_if),
    .tx_serial_out(tx2), .tx_busy_out(busy2), .tx_done_out(done2)
`ifdef UART_TX_CTS_EN
    , .cts_n_in(1'b0)
`endif
  );

  initial begin clk = 1'b0; forever #5 clk = ~clk; end

  initial begin
    int div;
    div = 0; baud = 1'b0;
    forever begin
      @(negedge clk);
      div = (div + 1) % 4;
      baud = (div == 0);
    end
  end

  always @(negedge clk) if (done0 === 1'b1) done_cnt0 = done_cnt0 + 1;

  function automatic logic line_of(input int inst);
    case (inst)
      0:       return tx0;
      1:       return tx1;
      default: return tx2;
    endcase
  endfunction

  // Wait for a start edge, then sample nbits at bit centres (bit 0 = start).
  // Returns in the middle of the last bit; wait_n = negedges spent waiting.
  task automatic recv(input int inst, input int nbits, output logic [11:0] bits, output int wait_n);
    bits = '0; wait_n = 0;
    @(negedge clk);
    while (line_of(inst) !== 1'b0 && wait_n < 4000) begin @(negedge clk); wait_n++; end
    if (wait_n >= 4000) return;
    repeat (16) @(negedge clk);
    bits[0] = line_of(inst);
    for (int i = 1; i < nbits; i++) begin
      repeat (32) @(negedge clk);
      bits[i] = line_of(inst);
    end
  endtask

  // Holds valid for n consecutive cycles with data base + step*i.
  task automatic push_burst(input int n, input logic [7:0] base, input logic [7:0] step);
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      m_if.wr_data_in  = 8'(int'(base) + int'(step) * i);
      m_if.wr_valid_in = 1'b1;
      @(posedge clk); #1;
    end
    m_if.wr_valid_in = 1'b0;
  endtask

  task automatic do_reset;
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (tx0 !== 1'b1) begin errors++; $display("FAIL rst_line: got %b want 1", tx0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy0); end
    checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done0); end
    checks++; if (m_if.fifo_level_out !== 5'd0) begin errors++; $display("FAIL rst_level: got %0d want 0", m_if.fifo_level_out); end
    checks++; if (m_if.wr_ready_out !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", m_if.wr_ready_out); end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // 0xA5 8N1: line 0,1,0,1,0,0,1,0,1,1 with 32-clock bits, one done pulse.
  task automatic test_single;
    logic [11:0] bits; int w, low, d0;
    d0 = done_cnt0;
    fork
      begin @(posedge clk); #1; m_if.wr_data_in = 8'hA5; m_if.wr_valid_in = 1'b1; @(posedge clk); #1; m_if.wr_valid_in = 1'b0; end
      recv(0, 10, bits, w);
      begin
        int n; n = 0; low = 0;
        @(negedge clk);
        while (tx0 !== 1'b0 && n < 4000) begin @(negedge clk); n++; end
        checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL t1_busy_during: got %b want 1", busy0); end
        while (tx0 === 1'b0 && low < 100) begin @(negedge clk); low++; end
        checks++; if (low != 32) begin errors++; $display("FAIL t1_start_len: got %0d clk want 32", low); end
      end
    join
    checks++; if (bits[9:0] !== 10'b1101001010) begin errors++; $display("FAIL t1_bits: got %b want 1101001010", bits[9:0]); end
    repeat (40) @(negedge clk);
    checks++; if (done_cnt0 - d0 != 1) begin errors++; $display("FAIL t1_done_pulses: got %0d want 1", done_cnt0 - d0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL t1_busy_after: got %b want 0", busy0); end
  endtask

  // 17 words back-to-back: one goes straight to the shift register, 16 fill
  // the FIFO so ready drops after the 17th accept. Frames must come in order
  // with no idle bit between them.
  task automatic test_back_to_back;
    int d0;
    d0 = done_cnt0;
    fork
      begin
        push_burst(17, 8'h11, 8'h13);
        @(negedge clk);
        checks++; if (m_if.wr_ready_out !== 1'b0) begin errors++; $display("FAIL t2_ready_full: got %b want 0", m_if.wr_ready_out); end
        checks++; if (m_if.fifo_level_out !== 5'd16) begin errors++; $display("FAIL t2_level_full: got %0d want 16", m_if.fifo_level_out); end
      end
      begin
        logic [11:0] bits; logic [7:0] d; int w;
        for (int f = 0; f < 17; f++) begin
          recv(0, 10, bits, w);
          d = 8'(8'h11 + 8'h13 * f);
          checks++; if (bits[9:0] !== {1'b1, d, 1'b0}) begin errors++; $display("FAIL t2_frame%0d: got %b want %b", f, bits[9:0], {1'b1, d, 1'b0}); end
          if (f > 0) begin
            checks++; if (w >= 32) begin errors++; $display("FAIL t2_gap%0d: got %0d clk want <32", f, w); end
          end
        end
      end
    join
    repeat (40) @(negedge clk);
    checks++; if (done_cnt0 - d0 != 17) begin errors++; $display("FAIL t2_done_pulses: got %0d want 17", done_cnt0 - d0); end
  endtask

  // Even parity of 0x07 is 1, odd parity 0; dut_p has two stop bits, checked
  // by a second queued frame that may not start inside them.
  task automatic test_parity_stop;
    fork
      begin
        @(posedge clk); #1;
        p_if.wr_data_in = 8'h07; p_if.wr_valid_in = 1'b1;
        o_if.wr_data_in = 8'h07; o_if.wr_valid_in = 1'b1;
        @(posedge clk); #1;
        p_if.wr_data_in = 8'h00; o_if.wr_valid_in = 1'b0;
        @(posedge clk); #1;
        p_if.wr_valid_in = 1'b0;
      end
      begin
        logic [11:0] b; int w;
        recv(1, 12, b, w);
        checks++; if (b !== 12'b111000001110) begin errors++; $display("FAIL t3_even_07: got %b want 111000001110", b); end
        recv(1, 12, b, w);
        checks++; if (b !== 12'b110000000000) begin errors++; $display("FAIL t3_even_00: got %b want 110000000000", b); end
        checks++; if (w >= 32) begin errors++; $display("FAIL t3_even_gap: got %0d clk want <32", w); end
      end
      begin
        logic [11:0] b; int w;
        recv(2, 11, b, w);
        checks++; if (b[10:0] !== 11'b10000001110) begin errors++; $display("FAIL t3_odd_07: got %b want 10000001110", b[10:0]); end
      end
    join
    repeat (60) @(negedge clk);
  endtask

  // Reset during the low data bits of 0x3C with 5 more queued.
  task automatic test_reset_mid_frame;
    int lows;
    push_burst(6, 8'h3C, 8'h01);
    repeat (60) @(negedge clk);
    checks++; if (tx0 !== 1'b0 || busy0 !== 1'b1) begin errors++; $display("FAIL t4_pre_state: got line=%b busy=%b want line=0 busy=1", tx0, busy0); end
    checks++; if (m_if.fifo_level_out !== 5'd5) begin errors++; $display("FAIL t4_pre_level: got %0d want 5", m_if.fifo_level_out); end
    do_reset();
    @(negedge clk);
    checks++; if (tx0 !== 1'b1) begin errors++; $display("FAIL t4_line: got %b want 1", tx0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL t4_busy: got %b want 0", busy0); end
    checks++; if (m_if.fifo_level_out !== 5'd0) begin errors++; $display("FAIL t4_level: got %0d want 0", m_if.fifo_level_out); end
    checks++; if (m_if.wr_ready_out !== 1'b1) begin errors++; $display("FAIL t4_ready: got %b want 1", m_if.wr_ready_out); end
    lows = 0;
    repeat (200) begin @(negedge clk); if (tx0 !== 1'b1) lows++; end
    checks++; if (lows != 0) begin errors++; $display("FAIL t4_flushed: got %0d low clk want 0", lows); end
  endtask

  // Full FIFO with valid held: the pop cycle refuses the push (level 15),
  // the following cycle accepts it (level 16).
  task automatic test_full_pop;
    int n;
    push_burst(17, 8'h40, 8'h01);
    @(negedge clk);
    checks++; if (m_if.fifo_level_out !== 5'd16) begin errors++; $display("FAIL t5_level_full: got %0d want 16", m_if.fifo_level_out); end
    @(posedge clk); #1;
    m_if.wr_data_in = 8'hEE; m_if.wr_valid_in = 1'b1;
    n = 0;
    @(negedge clk);
    while (m_if.fifo_level_out === 5'd16 && n < 1000) begin @(negedge clk); n++; end
    checks++; if (m_if.fifo_level_out !== 5'd15 || m_if.wr_ready_out !== 1'b1) begin errors++; $display("FAIL t5_pop_cycle: got level=%0d ready=%b want level=15 ready=1", m_if.fifo_level_out, m_if.wr_ready_out); end
    @(negedge clk);
    checks++; if (m_if.fifo_level_out !== 5'd16 || m_if.wr_ready_out !== 1'b0) begin errors++; $display("FAIL t5_refill: got level=%0d ready=%b want level=16 ready=0", m_if.fifo_level_out, m_if.wr_ready_out); end
    @(posedge clk); #1 m_if.wr_valid_in = 1'b0;
    do_reset();
    repeat (4) @(negedge clk);
  endtask

`ifdef UART_TX_CTS_EN
  task automatic test_cts;
    int lows, n;
    cts_n = 1'b1;
    do_reset();
    push_burst(3, 8'h55, 8'h01);
    lows = 0;
    repeat (300) begin @(negedge clk); if (tx0 !== 1'b1) lows++; end
    checks++; if (lows != 0) begin errors++; $display("FAIL t6_held: got %0d low clk want 0", lows); end
    checks++; if (m_if.fifo_level_out !== 5'd3) begin errors++; $display("FAIL t6_level_held: got %0d want 3", m_if.fifo_level_out); end
    @(posedge clk); #1 cts_n = 1'b0;
    n = 0;
    @(negedge clk);
    while (tx0 !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    checks++; if (n > 8) begin errors++; $display("FAIL t6_start_latency: got %0d clk want <=8", n); end
    checks++; if (m_if.fifo_level_out !== 5'd2) begin errors++; $display("FAIL t6_level_run: got %0d want 2", m_if.fifo_level_out); end
    do_reset();
    repeat (4) @(negedge clk);
  endtask
`endif

  initial begin
    errors = 0; checks = 0; done_cnt0 = 0;
    rst_n = 1'b0;
    m_if.wr_valid_in = 1'b0; m_if.wr_data_in = '0;
    p_if.wr_valid_in = 1'b0; p_if.wr_data_in = '0;
    o_if.wr_valid_in = 1'b0; o_if.wr_data_in = '0;
`ifdef UART_TX_CTS_EN
    cts_n = 1'b0;
`endif
    test_reset();
    test_single();
    test_back_to_back();
    test_parity_stop();
    test_reset_mid_frame();
    test_full_pop();
`ifdef UART_TX_CTS_EN
    test_cts();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
